// File: rtl/control_options_bank.sv
// Keyed bank of NREGS option registers on the ZX-UNO register bus. Writes land in
// shadow copies and only reach the live outputs as a whole set on an apply event.
module control_options_bank #(
  parameter int unsigned        NREGS        = 4,
  parameter logic [7:0]         BASE_ADDR    = 8'h0E,
  parameter logic [7:0]         CTRL_ADDR    = 8'h0D,
  parameter logic [8*NREGS-1:0] RESET_VALUES = '0,
  parameter logic [8*NREGS-1:0] WR_MASK      = '1,
  parameter bit                 KEYED        = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [7:0]         zxuno_addr,
  input  logic               zxuno_regrd,
  input  logic               zxuno_regwr,
  input  logic [7:0]         din,
  input  logic               apply_strobe,
  output logic [7:0]         dout,
  output logic               oe_n,
  output logic [8*NREGS-1:0] options,
  output logic               pending
);

  typedef enum logic [1:0] {
    StLocked   = 2'b00,
    StKey1     = 2'b01,
    StUnlocked = 2'b10
  } state_e;

  localparam state_e ResetState = state_e'(KEYED ? 2'b00 : 2'b10);

  state_e             state_q, state_d;
  logic               wr_q;
  logic [8*NREGS-1:0] shadow_q, shadow_d;
  logic [8*NREGS-1:0] live_q, live_d;
  logic               pending_q, pending_d;

  logic       wr_ev, ctrl_hit, win_hit, unlocked, opt_wr, apply_ev;
  logic [7:0] win_idx;

  // wr_q resets high so a strobe already asserted when rst drops is not an event.
  assign wr_ev    = zxuno_regwr & ~wr_q;
  assign ctrl_hit = (zxuno_addr == CTRL_ADDR);
  assign win_idx  = zxuno_addr - BASE_ADDR;
  assign win_hit  = (win_idx < 8'(NREGS));
  assign unlocked = (state_q == StUnlocked);
  assign opt_wr   = wr_ev & win_hit & unlocked;
  assign apply_ev = apply_strobe | (wr_ev & ctrl_hit & unlocked & din[7]);

  always_comb begin
    state_d = state_q;
    if (KEYED && wr_ev) begin
      unique case (state_q)
        StLocked:   if (ctrl_hit && din == 8'h55) state_d = StKey1;
        StKey1:     state_d = (ctrl_hit && din == 8'hAA) ? StUnlocked : StLocked;
        StUnlocked: if (ctrl_hit && !din[0]) state_d = StLocked;
        default:    state_d = StLocked;
      endcase
    end
  end

  always_comb begin
    shadow_d  = shadow_q;
    live_d    = live_q;
    pending_d = pending_q;
    for (int i = 0; i < int'(NREGS); i++) begin
      if (opt_wr && win_idx == 8'(i)) begin
        shadow_d[8*i +: 8] = (din & WR_MASK[8*i +: 8]) |
                             (RESET_VALUES[8*i +: 8] & ~WR_MASK[8*i +: 8]);
      end
    end
    // Apply commits the pre-write shadows; a same-cycle write stays outstanding.
    if (apply_ev && pending_q) begin
      live_d    = shadow_q;
      pending_d = 1'b0;
    end
    if (opt_wr) pending_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ResetState;
      wr_q      <= 1'b1;
      shadow_q  <= RESET_VALUES;
      live_q    <= RESET_VALUES;
      pending_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wr_q      <= zxuno_regwr;
      shadow_q  <= shadow_d;
      live_q    <= live_d;
      pending_q <= pending_d;
    end
  end

  always_comb begin
    dout = 8'hFF;
    oe_n = 1'b1;
    if (zxuno_regrd) begin
      if (win_hit) begin
        oe_n = 1'b0;
        for (int i = 0; i < int'(NREGS); i++) begin
          if (win_idx == 8'(i)) dout = shadow_q[8*i +: 8];
        end
      end else if (ctrl_hit) begin
        oe_n = 1'b0;
        dout = {pending_q, 5'b0, state_q};
      end
    end
  end

  assign options = live_q;
  assign pending = pending_q;

endmodule

// File: tb/tb_control_options_bank.sv
// Directed table-driven bench for control_options_bank plus hand-written multi-cycle cases.
module tb_control_options_bank;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  zxuno_addr = 8'h00;
  logic        zxuno_regrd = 1'b0;
  logic        zxuno_regwr = 1'b0;
  logic [7:0]  din = 8'h00;
  logic        apply_strobe = 1'b0;
  logic [7:0]  dout;
  logic        oe_n;
  logic [31:0] options;
  logic        pending;

  int total = 0;
  int bad   = 0;

  control_options_bank #(
    .NREGS       (4),
    .BASE_ADDR   (8'h0E),
    .CTRL_ADDR   (8'h0D),
    .RESET_VALUES(32'h0000_0000),
    .WR_MASK     (32'hFFFF_FF0F),
    .KEYED       (1'b1)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .zxuno_addr  (zxuno_addr),
    .zxuno_regrd (zxuno_regrd),
    .zxuno_regwr (zxuno_regwr),
    .din         (din),
    .apply_strobe(apply_strobe),
    .dout        (dout),
    .oe_n        (oe_n),
    .options     (options),
    .pending     (pending)
  );

  always #5 clk = ~clk;

  localparam int OpWr = 0, OpRd = 1, OpApply = 2, OpIdle = 3;

  typedef struct {
    int          op;
    logic [7:0]  addr;
    logic [7:0]  data;
    logic [7:0]  exp_dout;
    logic        exp_oe_n;
    logic [31:0] exp_opt;
    logic        exp_pend;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_write(input logic [7:0] a, input logic [7:0] d, input int hold);
    @(posedge clk); #1;
    zxuno_addr  = a;
    din         = d;
    zxuno_regwr = 1'b1;
    repeat (hold) @(posedge clk);
    #1 zxuno_regwr = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic do_read(input string name, input logic [7:0] a, input logic [7:0] exp_d,
                         input logic exp_oe);
    zxuno_addr  = a;
    zxuno_regrd = 1'b1;
    #1;
    check({name, " dout"}, {24'b0, dout}, {24'b0, exp_d});
    check({name, " oe_n"}, {31'b0, oe_n}, {31'b0, exp_oe});
    zxuno_regrd = 1'b0;
    #1;
  endtask

  task automatic do_apply();
    @(posedge clk); #1 apply_strobe = 1'b1;
    @(posedge clk); #1 apply_strobe = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Locked write ignored, unlock, stage 3C in reg1, apply.
    vecs.push_back('{OpWr,   8'h0E, 8'h3C, 8'h00, 1'b0, 32'h0000_0000, 1'b0});
    vecs.push_back('{OpRd,   8'h0E, 8'h00, 8'h00, 1'b0, 32'h0000_0000, 1'b0});
    vecs.push_back('{OpWr,   8'h0D, 8'h55, 8'h00, 1'b0, 32'h0000_0000, 1'b0});
    vecs.push_back('{OpRd,   8'h0D, 8'h00, 8'h01, 1'b0, 32'h0000_0000, 1'b0});
    vecs.push_back('{OpWr,   8'h0D, 8'hAA, 8'h00, 1'b0, 32'h0000_0000, 1'b0});
    vecs.push_back('{OpRd,   8'h0D, 8'h00, 8'h02, 1'b0, 32'h0000_0000, 1'b0});
    vecs.push_back('{OpWr,   8'h0F, 8'h3C, 8'h00, 1'b0, 32'h0000_0000, 1'b1});
    vecs.push_back('{OpRd,   8'h0D, 8'h00, 8'h82, 1'b0, 32'h0000_0000, 1'b1});
    vecs.push_back('{OpRd,   8'h0F, 8'h00, 8'h3C, 1'b0, 32'h0000_0000, 1'b1});
    vecs.push_back('{OpApply, 8'h00, 8'h00, 8'h00, 1'b0, 32'h0000_3C00, 1'b0});
    vecs.push_back('{OpRd,   8'h0D, 8'h00, 8'h02, 1'b0, 32'h0000_3C00, 1'b0});
    vecs.push_back('{OpIdle, 8'h0D, 8'h00, 8'hFF, 1'b1, 32'h0000_3C00, 1'b0});
    vecs.push_back('{OpRd,   8'h20, 8'h00, 8'hFF, 1'b1, 32'h0000_3C00, 1'b0});
    vecs.push_back('{OpRd,   8'h12, 8'h00, 8'hFF, 1'b1, 32'h0000_3C00, 1'b0});
    // Relock, then a broken key sequence must not store or unlock.
    vecs.push_back('{OpWr,   8'h0D, 8'h00, 8'h00, 1'b0, 32'h0000_3C00, 1'b0});
    vecs.push_back('{OpRd,   8'h0D, 8'h00, 8'h00, 1'b0, 32'h0000_3C00, 1'b0});
    vecs.push_back('{OpWr,   8'h0D, 8'h55, 8'h00, 1'b0, 32'h0000_3C00, 1'b0});
    vecs.push_back('{OpWr,   8'h0E, 8'h12, 8'h00, 1'b0, 32'h0000_3C00, 1'b0});
    vecs.push_back('{OpRd,   8'h0D, 8'h00, 8'h00, 1'b0, 32'h0000_3C00, 1'b0});
    vecs.push_back('{OpWr,   8'h0D, 8'hAA, 8'h00, 1'b0, 32'h0000_3C00, 1'b0});
    vecs.push_back('{OpRd,   8'h0D, 8'h00, 8'h00, 1'b0, 32'h0000_3C00, 1'b0});
    vecs.push_back('{OpRd,   8'h0E, 8'h00, 8'h00, 1'b0, 32'h0000_3C00, 1'b0});
    // Masked write to reg0, then CTRL 80 applies and relocks.
    vecs.push_back('{OpWr,   8'h0D, 8'h55, 8'h00, 1'b0, 32'h0000_3C00, 1'b0});
    vecs.push_back('{OpWr,   8'h0D, 8'hAA, 8'h00, 1'b0, 32'h0000_3C00, 1'b0});
    vecs.push_back('{OpWr,   8'h0E, 8'hFF, 8'h00, 1'b0, 32'h0000_3C00, 1'b1});
    vecs.push_back('{OpRd,   8'h0E, 8'h00, 8'h0F, 1'b0, 32'h0000_3C00, 1'b1});
    vecs.push_back('{OpWr,   8'h0D, 8'h80, 8'h00, 1'b0, 32'h0000_3C0F, 1'b0});
    vecs.push_back('{OpRd,   8'h0D, 8'h00, 8'h00, 1'b0, 32'h0000_3C0F, 1'b0});

    #22 rst = 1'b0;
    @(posedge clk); #1;
    check("reset options", options, 32'h0);
    check("reset pending", {31'b0, pending}, 32'h0);
    do_read("reset ctrl", 8'h0D, 8'h00, 1'b0);

    foreach (vecs[k]) begin
      case (vecs[k].op)
        OpWr:    do_write(vecs[k].addr, vecs[k].data, 1);
        OpApply: do_apply();
        OpRd:    do_read($sformatf("vec%0d read", k), vecs[k].addr, vecs[k].exp_dout,
                         vecs[k].exp_oe_n);
        default: begin
          zxuno_addr = vecs[k].addr;
          #1;
          check($sformatf("vec%0d idle dout", k), {24'b0, dout}, {24'b0, vecs[k].exp_dout});
          check($sformatf("vec%0d idle oe_n", k), {31'b0, oe_n}, {31'b0, vecs[k].exp_oe_n});
        end
      endcase
      check($sformatf("vec%0d options", k), options, vecs[k].exp_opt);
      check($sformatf("vec%0d pending", k), {31'b0, pending}, {31'b0, vecs[k].exp_pend});
    end

    // Long strobes: each must count as a single write event.
    do_write(8'h0D, 8'h55, 5);
    do_read("held 55 ctrl", 8'h0D, 8'h01, 1'b0);
    do_write(8'h0D, 8'hAA, 5);
    do_read("held AA ctrl", 8'h0D, 8'h02, 1'b0);

    // Same-cycle option write and apply: live takes the pre-write shadow.
    do_write(8'h0F, 8'h77, 1);
    check("pre-collide pending", {31'b0, pending}, 32'h1);
    @(posedge clk); #1;
    zxuno_addr   = 8'h0E;
    din          = 8'h05;
    zxuno_regwr  = 1'b1;
    apply_strobe = 1'b1;
    #1 check("apply not before edge", options, 32'h0000_3C0F);
    @(posedge clk); #1;
    zxuno_regwr  = 1'b0;
    apply_strobe = 1'b0;
    check("collide options", options, 32'h0000_770F);
    check("collide pending", {31'b0, pending}, 32'h1);
    do_read("collide shadow0", 8'h0E, 8'h05, 1'b0);
    do_apply();
    check("second apply options", options, 32'h0000_7705);
    check("second apply pending", {31'b0, pending}, 32'h0);
    do_apply();
    check("apply idle options", options, 32'h0000_7705);

    // Mid-sequence reset discards staged data; a strobe held across reset release is ignored.
    do_write(8'h10, 8'h11, 1);
    check("staged pending", {31'b0, pending}, 32'h1);
    zxuno_addr  = 8'h0D;
    din         = 8'h55;
    zxuno_regwr = 1'b1;
    rst         = 1'b1;
    #1;
    check("async reset options", options, 32'h0);
    check("async reset pending", {31'b0, pending}, 32'h0);
    @(posedge clk); #1 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1 zxuno_regwr = 1'b0;
    do_read("strobe across reset ctrl", 8'h0D, 8'h00, 1'b0);
    do_read("reset shadow2", 8'h10, 8'h00, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
